vga_board_renderer: RTL and testbench

- Pixel-generation stage directly downstream of the VGA timing driver.
- Consumes pixel coordinates x/y, video_on, hsync, vsync and blank, and produces 8-bit R/G/B for the ADV7123-class DAC.
- Renders a COLS x ROWS game board from an internal cell-state memory written by game logic, with a blinking cursor column.
- Delays sync and blank to match the 2-cycle colour pipeline.

---
 rtl/vga_board_pkg.sv | 28 ++
 rtl/vga_board_renderer_if.sv | 32 +++
 rtl/board_cell_mem.sv | 42 ++++
 rtl/vga_board_renderer.sv | 180 ++++++++++++++++++
 tb/tb_vga_board_renderer.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_board_pkg.sv
// Shared types and constants for the VGA board renderer.
// Optional build macro GRID_LINES_EN (consumed by vga_board_renderer) adds cell grid lines.
package vga_board_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    PLAYER_A = 2'd1,
    PLAYER_B = 2'd2,
    HILITE   = 2'd3
  } cell_t;

  localparam logic [23:0] COL_BLACK  = 24'h000000;
  localparam logic [23:0] COL_BOARD  = 24'h0000C0;
  localparam logic [23:0] COL_A      = 24'hFF0000;
  localparam logic [23:0] COL_B      = 24'hFFFF00;
  localparam logic [23:0] COL_HILITE = 24'h00FF00;
  localparam logic [23:0] COL_CURSOR = 24'h4040FF;
  localparam logic [23:0] COL_GRID   = 24'hFFFFFF;

  // Depth of the colour pipeline; sync/blank are delayed by the same amount.
  localparam int PIPE_DEPTH = 2;

  // True when an in-cell offset sits on the first or last pixel of the cell.
  function automatic logic grid_hit(input logic [9:0] off, input logic [9:0] last);
    return (off == 10'd0) || (off == last);
  endfunction

endpackage

// File: rtl/vga_board_renderer_if.sv
// Pixel-stream, cell-write and DAC-side signals of the board renderer.
interface vga_board_renderer_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       video_on;
  logic       hsync_in;
  logic       vsync_in;
  logic       blank_in;
  logic       wr_en;
  logic [2:0] wr_col;
  logic [2:0] wr_row;
  logic [1:0] wr_data;
  logic [2:0] cursor_col;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic       hsync;
  logic       vsync;
  logic       blank;

  modport master (
    output x, y, video_on, hsync_in, vsync_in, blank_in,
    output wr_en, wr_col, wr_row, wr_data, cursor_col,
    input  r, g, b, hsync, vsync, blank
  );

  modport slave (
    input  x, y, video_on, hsync_in, vsync_in, blank_in,
    input  wr_en, wr_col, wr_row, wr_data, cursor_col,
    output r, g, b, hsync, vsync, blank
  );
endinterface

// File: rtl/board_cell_mem.sv
// 64 x 2-bit cell-state register file: one range-checked synchronous write
// port, one combinational read port. Reads see the pre-write value during
// the write cycle.
module board_cell_mem
  import vga_board_pkg::*;
#(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_col,
  input  logic [2:0] wr_row,
  input  logic [1:0] wr_data,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output cell_t      rd_data
);

  localparam logic [3:0] COLS_L = 4'(COLS);
  localparam logic [3:0] ROWS_L = 4'(ROWS);

  logic [1:0] cells_r [64];
  logic       wr_ok_s;

  assign wr_ok_s = wr_en && ({1'b0, wr_col} < COLS_L) && ({1'b0, wr_row} < ROWS_L);

  // Cell storage: cleared on reset, written only for on-board addresses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 64; i++) begin
        cells_r[i] <= 2'd0;
      end
    end else if (wr_ok_s) begin
      cells_r[{wr_row, wr_col}] <= wr_data;
    end
  end

  assign rd_data = cell_t'(cells_r[{rd_row, rd_col}]);

endmodule

// File: rtl/vga_board_renderer.sv
// Board pixel generator behind the VGA timing driver. Two-stage pipeline:
// stage 1 maps x/y to board cell and in-cell offset, stage 2 reads the cell
// and registers the colour. Sync/blank get the same 2-clock delay.
// Build macro GRID_LINES_EN: draw white grid lines on cell borders.
module vga_board_renderer
  import vga_board_pkg::*;
#(
  parameter int COLS         = 7,
  parameter int ROWS         = 6,
  parameter int CELL_LOG2    = 6,
  parameter int X0           = 96,
  parameter int Y0           = 48,
  parameter int BLINK_FRAMES = 15
) (
  input logic                 clk,
  input logic                 reset,
  vga_board_renderer_if.slave bus
);

`ifdef GRID_LINES_EN
  localparam logic GRID_EN = 1'b1;
`else
  localparam logic GRID_EN = 1'b0;
`endif

  localparam logic [10:0] BOARD_W   = 11'(COLS << CELL_LOG2);
  localparam logic [10:0] BOARD_H   = 11'(ROWS << CELL_LOG2);
  localparam logic [9:0]  CELL_LAST = 10'((1 << CELL_LOG2) - 1);
  localparam logic [5:0]  BLINK_LAST = 6'(BLINK_FRAMES - 1);
  localparam logic [3:0]  COLS_L    = 4'(COLS);

  // Stage 1 combinational mapping
  logic [9:0] dx_s, dy_s;
  logic       in_board_s;

  // Stage 1 registers
  logic                 s1_valid_r;
  logic                 s1_video_on_r;
  logic                 s1_in_board_r;
  logic [2:0]           s1_col_r, s1_row_r;
  logic [CELL_LOG2-1:0] s1_off_x_r, s1_off_y_r;

  // Stage 2
  cell_t       cell_s;
  logic        cursor_on_s;
  logic        grid_s;
  logic [23:0] colour_s;
  logic [23:0] rgb_r;

  // Sync/blank delay lines
  logic [PIPE_DEPTH-1:0] hs_pipe_r, vs_pipe_r, bl_pipe_r;

  // Frame / blink
  logic       vs_prev_r;
  logic       frame_tick_s;
  logic [5:0] frame_cnt_r;
  logic       blink_r;

  // Since dx wraps modulo 1024, x >= X0 plus dx < width is exactly the
  // X0 <= x < X0 + width window.
  assign dx_s = bus.x - 10'(X0);
  assign dy_s = bus.y - 10'(Y0);
  assign in_board_s = (bus.x >= 10'(X0)) && ({1'b0, dx_s} < BOARD_W) &&
                      (bus.y >= 10'(Y0)) && ({1'b0, dy_s} < BOARD_H);

  // Stage 1: register cell coordinates, offsets and video_on.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r    <= 1'b0;
      s1_video_on_r <= 1'b0;
      s1_in_board_r <= 1'b0;
      s1_col_r      <= 3'd0;
      s1_row_r      <= 3'd0;
      s1_off_x_r    <= '0;
      s1_off_y_r    <= '0;
    end else begin
      s1_valid_r    <= 1'b1;
      s1_video_on_r <= bus.video_on;
      s1_in_board_r <= in_board_s;
      s1_col_r      <= dx_s[CELL_LOG2 +: 3];
      s1_row_r      <= dy_s[CELL_LOG2 +: 3];
      s1_off_x_r    <= dx_s[CELL_LOG2-1:0];
      s1_off_y_r    <= dy_s[CELL_LOG2-1:0];
    end
  end

  board_cell_mem #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cells (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (bus.wr_en),
    .wr_col  (bus.wr_col),
    .wr_row  (bus.wr_row),
    .wr_data (bus.wr_data),
    .rd_col  (s1_col_r),
    .rd_row  (s1_row_r),
    .rd_data (cell_s)
  );

  assign cursor_on_s = ({1'b0, bus.cursor_col} < COLS_L) && (bus.cursor_col == s1_col_r);
  assign grid_s = GRID_EN && (grid_hit(10'(s1_off_x_r), CELL_LAST) ||
                              grid_hit(10'(s1_off_y_r), CELL_LAST));

  // Stage 2 colour selection in priority order.
  always_comb begin
    colour_s = COL_BLACK;
    if (!s1_valid_r || !s1_video_on_r || !s1_in_board_r) begin
      colour_s = COL_BLACK;
    end else if (grid_s) begin
      colour_s = COL_GRID;
    end else begin
      case (cell_s)
        PLAYER_A: colour_s = COL_A;
        PLAYER_B: colour_s = COL_B;
        HILITE:   colour_s = COL_HILITE;
        EMPTY: begin
          if (cursor_on_s && blink_r) begin
            colour_s = COL_CURSOR;
          end else begin
            colour_s = COL_BOARD;
          end
        end
        default:  colour_s = COL_BOARD;
      endcase
    end
  end

  // Stage 2: registered colour output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r <= COL_BLACK;
    end else begin
      rgb_r <= colour_s;
    end
  end

  // Sync/blank delay matching the colour pipeline; syncs idle high, blank_n low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_pipe_r <= {PIPE_DEPTH{1'b1}};
      vs_pipe_r <= {PIPE_DEPTH{1'b1}};
      bl_pipe_r <= {PIPE_DEPTH{1'b0}};
    end else begin
      hs_pipe_r <= {hs_pipe_r[PIPE_DEPTH-2:0], bus.hsync_in};
      vs_pipe_r <= {vs_pipe_r[PIPE_DEPTH-2:0], bus.vsync_in};
      bl_pipe_r <= {bl_pipe_r[PIPE_DEPTH-2:0], bus.blank_in};
    end
  end

  assign frame_tick_s = vs_prev_r && !bus.vsync_in;

  // Frame counter on vsync falling edges; blink phase flips every BLINK_FRAMES ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_prev_r   <= 1'b1;
      frame_cnt_r <= 6'd0;
      blink_r     <= 1'b0;
    end else begin
      vs_prev_r <= bus.vsync_in;
      if (frame_tick_s) begin
        if (frame_cnt_r == BLINK_LAST) begin
          frame_cnt_r <= 6'd0;
          blink_r     <= ~blink_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + 6'd1;
        end
      end
    end
  end

  assign bus.r     = rgb_r[23:16];
  assign bus.g     = rgb_r[15:8];
  assign bus.b     = rgb_r[7:0];
  assign bus.hsync = hs_pipe_r[PIPE_DEPTH-1];
  assign bus.vsync = vs_pipe_r[PIPE_DEPTH-1];
  assign bus.blank = bl_pipe_r[PIPE_DEPTH-1];

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer (default parameters).
module tb_vga_board_renderer;

`ifdef GRID_LINES_EN
  localparam logic GRID = 1'b1;
`else
  localparam logic GRID = 1'b0;
`endif

  localparam logic [23:0] BLACK  = 24'h000000;
  localparam logic [23:0] BLUE   = 24'h0000C0;
  localparam logic [23:0] RED    = 24'hFF0000;
  localparam logic [23:0] GREEN  = 24'h00FF00;
  localparam logic [23:0] CURSOR = 24'h4040FF;
  localparam logic [23:0] WHITE  = 24'hFFFFFF;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  vga_board_renderer_if bus ();

  vga_board_renderer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a pixel at a falling edge and wait out the 2-clock latency.
  task automatic show(input logic [9:0] px, input logic [9:0] py, input logic von);
    @(negedge clk);
    bus.x = px;
    bus.y = py;
    bus.video_on = von;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] c, input logic [2:0] r, input logic [1:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_col = c;
    bus.wr_row = r;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic vpulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.vsync_in = 1'b0;
      @(negedge clk);
      bus.vsync_in = 1'b1;
    end
  endtask

  function automatic logic [23:0] rgb();
    return {bus.r, bus.g, bus.b};
  endfunction

  initial begin
    n_checks = 0;
    n_fail = 0;
    reset = 1'b1;
    bus.x = 10'd0;
    bus.y = 10'd0;
    bus.video_on = 1'b0;
    bus.hsync_in = 1'b1;
    bus.vsync_in = 1'b1;
    bus.blank_in = 1'b0;
    bus.wr_en = 1'b0;
    bus.wr_col = 3'd0;
    bus.wr_row = 3'd0;
    bus.wr_data = 2'd0;
    bus.cursor_col = 3'd7;

    repeat (3) @(negedge clk);
    check("reset_rgb", rgb(), BLACK);
    check("reset_hsync", 24'(bus.hsync), 24'd1);
    check("reset_vsync", 24'(bus.vsync), 24'd1);
    check("reset_blank", 24'(bus.blank), 24'd0);
    reset = 1'b0;

    // Cells start empty.
    show(10'd256, 10'd272, 1'b1);
    check("empty_2_3", rgb(), BLUE);

    // Cell colour with exact 2-clock latency.
    wr(3'd2, 3'd3, 2'd1);
    show(10'd50, 10'd100, 1'b1);
    check("outside_50_100", rgb(), BLACK);
    @(negedge clk);
    bus.x = 10'd256;
    bus.y = 10'd272;
    @(negedge clk);
    check("latency_1clk", rgb(), BLACK);
    @(negedge clk);
    check("latency_2clk_red", rgb(), RED);
    show(10'd320, 10'd272, 1'b1);
    check("neighbour_blue", rgb(), BLUE);

    // Out-of-range writes are dropped; sweep every cell centre.
    wr(3'd7, 3'd0, 2'd2);
    wr(3'd0, 3'd6, 2'd2);
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 7; c++) begin
        show(10'(128 + 64 * c), 10'(80 + 64 * r), 1'b1);
        check($sformatf("sweep_c%0d_r%0d", c, r), rgb(), (c == 2 && r == 3) ? RED : BLUE);
      end
    end
    show(10'd576, 10'd80, 1'b1);
    check("col7_outside", rgb(), BLACK);
    show(10'd128, 10'd464, 1'b1);
    check("row6_outside", rgb(), BLACK);

    // Blanking and board edges.
    show(10'd256, 10'd272, 1'b0);
    check("video_off", rgb(), BLACK);
    show(10'd95, 10'd272, 1'b1);
    check("left_edge_out", rgb(), BLACK);
    show(10'd96, 10'd272, 1'b1);
    check("left_edge_in", rgb(), GRID ? WHITE : BLUE);
    show(10'd543, 10'd272, 1'b1);
    check("right_edge_in", rgb(), GRID ? WHITE : BLUE);
    show(10'd544, 10'd272, 1'b1);
    check("right_edge_out", rgb(), BLACK);
    show(10'd256, 10'd47, 1'b1);
    check("top_edge_out", rgb(), BLACK);
    show(10'd256, 10'd431, 1'b1);
    check("bottom_edge_in", rgb(), GRID ? WHITE : BLUE);
    show(10'd256, 10'd432, 1'b1);
    check("bottom_edge_out", rgb(), BLACK);

    // hsync/blank one-cycle pulses appear two clocks later.
    @(negedge clk);
    bus.hsync_in = 1'b0;
    bus.blank_in = 1'b1;
    @(negedge clk);
    bus.hsync_in = 1'b1;
    bus.blank_in = 1'b0;
    check("hsync_n1", 24'(bus.hsync), 24'd1);
    check("blank_n1", 24'(bus.blank), 24'd0);
    @(negedge clk);
    check("hsync_n2", 24'(bus.hsync), 24'd0);
    check("blank_n2", 24'(bus.blank), 24'd1);
    @(negedge clk);
    check("hsync_n3", 24'(bus.hsync), 24'd1);
    check("blank_n3", 24'(bus.blank), 24'd0);

    // Read/write collision on cell (5,1).
    @(negedge clk);
    bus.x = 10'd448;
    bus.y = 10'd144;
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.wr_col = 3'd5;
    bus.wr_row = 3'd1;
    bus.wr_data = 2'd3;
    @(negedge clk);
    bus.wr_en = 1'b0;
    check("collision_old", rgb(), BLUE);
    @(negedge clk);
    check("collision_new", rgb(), GREEN);

    // Cursor blink on column 4.
    bus.cursor_col = 3'd4;
    show(10'd384, 10'd272, 1'b1);
    check("cursor_phase0", rgb(), BLUE);
    vpulses(14);
    show(10'd384, 10'd272, 1'b1);
    check("cursor_14_ticks", rgb(), BLUE);
    vpulses(1);
    show(10'd384, 10'd272, 1'b1);
    check("cursor_15_ticks", rgb(), CURSOR);
    show(10'd320, 10'd272, 1'b1);
    check("cursor_other_col", rgb(), BLUE);
    vpulses(15);
    show(10'd384, 10'd272, 1'b1);
    check("cursor_30_ticks", rgb(), BLUE);
    vpulses(15);
    bus.cursor_col = 3'd7;
    show(10'd384, 10'd272, 1'b1);
    check("cursor_disabled", rgb(), BLUE);
    bus.cursor_col = 3'd4;
    show(10'd384, 10'd272, 1'b1);
    check("cursor_45_ticks", rgb(), CURSOR);

    // Asynchronous reset mid-line.
    bus.hsync_in = 1'b0;
    bus.blank_in = 1'b1;
    show(10'd256, 10'd272, 1'b1);
    check("pre_reset_red", rgb(), RED);
    check("pre_reset_hsync", 24'(bus.hsync), 24'd0);
    #5;
    reset = 1'b1;
    #1;
    check("async_reset_rgb", rgb(), BLACK);
    check("async_reset_hsync", 24'(bus.hsync), 24'd1);
    check("async_reset_vsync", 24'(bus.vsync), 24'd1);
    check("async_reset_blank", 24'(bus.blank), 24'd0);
    @(negedge clk);
    reset = 1'b0;
    bus.hsync_in = 1'b1;
    bus.blank_in = 1'b0;
    show(10'd256, 10'd272, 1'b1);
    check("post_reset_cell_2_3", rgb(), BLUE);
    show(10'd448, 10'd144, 1'b1);
    check("post_reset_cell_5_1", rgb(), BLUE);
    show(10'd384, 10'd272, 1'b1);
    check("post_reset_blink", rgb(), BLUE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
